// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the set-associative read cache.
// Holds the default parameter values, the controller state type and helpers
// that split a word address into tag / set index / word offset.
package cache_pkg;

  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_WORD_COUNT = 4;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_SETS       = 8;
  localparam int DEF_WAYS       = 2;
  localparam int DEF_CNT_WIDTH  = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // ob = offset bits, ib = index bits; callers truncate to the field width.
  function automatic int unsigned addr_offset(input int unsigned addr, input int ob);
    return addr & ((32'd1 << ob) - 32'd1);
  endfunction

  function automatic int unsigned addr_index(input int unsigned addr, input int ob,
                                             input int ib);
    return (addr >> ob) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic int unsigned addr_tag(input int unsigned addr, input int ob,
                                           input int ib);
    return addr >> (ob + ib);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set age-based LRU state.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   flush         restore every set's ages to the way index
//   set_idx       set being looked up / updated
//   valid         valid bits of the ways in set_idx
//   way           way being touched (hit or fill)
//   update        apply the age update for (set_idx, way)
//   victim        way to fill on a miss in set_idx
module cache_lru
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [$clog2(SETS)-1:0] set_idx,
  input  logic [WAYS-1:0]         valid,
  input  logic [$clog2(WAYS)-1:0] way,
  input  logic                    update,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int WB = $clog2(WAYS);

  logic [WB-1:0] age [SETS][WAYS];
  logic [WB-1:0] cur_age;
  logic          found;

  assign cur_age = age[set_idx][way];

  // Lowest invalid way first; otherwise the oldest way. Ages are a
  // permutation of 0..WAYS-1, so the oldest way carries the all-ones age.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = WB'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[set_idx][w] == '1) victim = WB'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WB'(w);
    end else if (flush) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WB'(w);
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WB'(w) == way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < cur_age)
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative word read cache with LRU fill.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake, req_addr = word address
//   resp_valid/data/hit       one-cycle response strobe, word, hit flag
//   flush                     invalidate all lines (taken in IDLE only)
//   mem_read/mem_addr         line fetch request, line-aligned address
//   mem_ready/mem_data        fetched line, accepted only while missing
//   access_count/hit_count    saturating statistics
//
// state  | meaning
// IDLE   | ready for a request or flush
// LOOKUP | compare all ways of the registered set
// MISS   | line fetch outstanding, waiting for mem_ready
// RESP   | response strobe cycle
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int WORD_COUNT = DEF_WORD_COUNT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  output logic                            resp_valid,
  output logic [WORD_SIZE-1:0]            resp_data,
  output logic                            resp_hit,
  input  logic                            flush,
  output logic                            mem_read,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_ready,
  input  logic [WORD_COUNT*WORD_SIZE-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]            access_count,
  output logic [CNT_WIDTH-1:0]            hit_count
);

  localparam int OB   = $clog2(WORD_COUNT);
  localparam int IB   = $clog2(SETS);
  localparam int WB   = $clog2(WAYS);
  localparam int TB   = ADDR_WIDTH - OB - IB;
  localparam int LINE = WORD_COUNT * WORD_SIZE;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TB-1:0]         tag_req;
  logic [IB-1:0]         idx_req;
  logic [OB-1:0]         off_req;

  logic [WAYS-1:0] valid_q [SETS];
  logic [TB-1:0]   tag_q   [SETS][WAYS];
  logic [LINE-1:0] data_q  [SETS][WAYS];

  logic          hit;
  logic [WB-1:0] hit_way;
  logic [WB-1:0] victim;
  logic [WB-1:0] lru_way;
  logic          lru_update;
  logic          accept;
  logic          flush_take;
  logic          fill;
  logic          hit_q;
  logic [WORD_SIZE-1:0] resp_data_q;

  assign tag_req = TB'(addr_tag(32'(addr_q), OB, IB));
  assign idx_req = IB'(addr_index(32'(addr_q), OB, IB));
  assign off_req = OB'(addr_offset(32'(addr_q), OB));

  assign accept     = (state == IDLE) && req_valid && !flush;
  assign flush_take = (state == IDLE) && flush;
  assign fill       = (state == MISS) && mem_ready;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_req][w] && (tag_q[idx_req][w] == tag_req)) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  assign lru_way    = (state == LOOKUP) ? hit_way : victim;
  assign lru_update = ((state == LOOKUP) && hit) || fill;

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush_take),
    .set_idx (idx_req),
    .valid   (valid_q[idx_req]),
    .way     (lru_way),
    .update  (lru_update),
    .victim  (victim)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? RESP : MISS;
      MISS:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = (state == IDLE) && !flush;
    resp_valid = (state == RESP);
    resp_hit   = (state == RESP) && hit_q;
    mem_read   = (state == MISS);
  end

  assign resp_data = resp_data_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:OB], {OB{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      hit_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (accept) addr_q <= req_addr;
      if ((state == LOOKUP) && hit) begin
        hit_q       <= 1'b1;
        resp_data_q <= data_q[idx_req][hit_way][off_req*WORD_SIZE +: WORD_SIZE];
      end else if (fill) begin
        hit_q       <= 1'b0;
        resp_data_q <= mem_data[off_req*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (flush_take) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill) begin
      valid_q[idx_req][victim] <= 1'b1;
    end
  end

  // Tag/data contents are qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx_req][victim]  <= tag_req;
      data_q[idx_req][victim] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      if (accept && (access_count != '1))
        access_count <= access_count + 1'b1;
      if ((state == LOOKUP) && hit && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed bench for set_assoc_cache. A second instance
// with 4-bit counters shares the stimulus and is used for saturation.
module tb_set_assoc_cache;

  localparam int AW = 15;
  localparam int WS = 32;
  localparam int WC = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic            flush = 1'b0;
  logic            mem_ready = 1'b0;
  logic [WC*WS-1:0] mem_data = '0;

  logic            req_ready, resp_valid, resp_hit, mem_read;
  logic [WS-1:0]   resp_data;
  logic [AW-1:0]   mem_addr;
  logic [13:0]     access_count, hit_count;

  logic            s_req_ready, s_resp_valid, s_resp_hit, s_mem_read;
  logic [WS-1:0]   s_resp_data;
  logic [AW-1:0]   s_mem_addr;
  logic [3:0]      s_access_count, s_hit_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_hit(resp_hit), .flush(flush), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .access_count(access_count),
    .hit_count(hit_count)
  );

  set_assoc_cache #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_addr(req_addr), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
    .resp_hit(s_resp_hit), .flush(flush), .mem_read(s_mem_read), .mem_addr(s_mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .access_count(s_access_count),
    .hit_count(s_hit_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line 0x0004 carries the hand-picked words; any other line returns
  // word i = 0x1000_0000 + line_addr*16 + i.
  function automatic logic [WC*WS-1:0] line_of(input logic [AW-1:0] la);
    logic [WC*WS-1:0] l;
    if (la == 15'h0004) begin
      l = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    end else begin
      for (int i = 0; i < WC; i++)
        l[i*WS +: WS] = 32'h1000_0000 + 32'(la) * 32'd16 + 32'(i);
    end
    return l;
  endfunction

  // Starts and ends #1 after a rising edge with the cache idle.
  task automatic read_word(input logic [AW-1:0] a, input bit exp_hit,
                           input logic [31:0] exp_data, input int wait_cyc);
    logic [AW-1:0] la;
    la = {a[AW-1:2], 2'b00};
    check("req_ready before accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("no resp in lookup", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    if (exp_hit) begin
      check("hit resp_valid", 32'(resp_valid), 32'd1);
      check("hit resp_hit", 32'(resp_hit), 32'd1);
      check("hit resp_data", resp_data, exp_data);
      check("hit no mem_read", 32'(mem_read), 32'd0);
    end else begin
      check("miss mem_read", 32'(mem_read), 32'd1);
      check("miss mem_addr", 32'(mem_addr), 32'(la));
      check("miss no resp", 32'(resp_valid), 32'd0);
      for (int i = 0; i < wait_cyc; i++) begin
        @(posedge clk); #1;
        check("wait mem_read held", 32'(mem_read), 32'd1);
        check("wait mem_addr held", 32'(mem_addr), 32'(la));
        check("wait no resp", 32'(resp_valid), 32'd0);
      end
      mem_ready = 1'b1;
      mem_data  = line_of(la);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_data  = '0;
      check("fill resp_valid", 32'(resp_valid), 32'd1);
      check("fill resp_hit", 32'(resp_hit), 32'd0);
      check("fill resp_data", resp_data, exp_data);
      check("fill mem_read drop", 32'(mem_read), 32'd0);
    end
    @(posedge clk); #1;
    check("resp one cycle", 32'(resp_valid), 32'd0);
    check("req_ready back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    check("rst mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_hit", 32'(resp_hit), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst access_count", 32'(access_count), 32'd0);
    check("rst hit_count", 32'(hit_count), 32'd0);

    // cold miss then hit
    read_word(15'h0004, 1'b0, 32'hA0, 0);
    read_word(15'h0006, 1'b1, 32'hC2, 0);
    check("cold access_count", 32'(access_count), 32'd2);
    check("cold hit_count", 32'(hit_count), 32'd1);

    // LRU: set 1 holds tags 0 and 1; touching tag 0 makes tag 1 the victim
    read_word(15'h0024, 1'b0, 32'h1000_0240, 0);
    read_word(15'h0004, 1'b1, 32'hA0, 0);
    read_word(15'h0044, 1'b0, 32'h1000_0440, 0);
    read_word(15'h0004, 1'b1, 32'hA0, 0);
    // evicted line, refetched with a 5-cycle memory wait
    read_word(15'h0024, 1'b0, 32'h1000_0240, 5);
    check("lru access_count", 32'(access_count), 32'd7);
    check("lru hit_count", 32'(hit_count), 32'd3);

    // flush has priority over a simultaneous request
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 15'h0004;
    #1;
    check("flush req_ready low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("flush no mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    check("flush no resp", 32'(resp_valid), 32'd0);
    check("flush access kept", 32'(access_count), 32'd7);
    check("flush hit kept", 32'(hit_count), 32'd3);
    read_word(15'h0004, 1'b0, 32'hA0, 0);
    check("post-flush access", 32'(access_count), 32'd8);
    check("post-flush hit", 32'(hit_count), 32'd3);

    // reset in the middle of a miss
    req_valid = 1'b1;
    req_addr  = 15'h0044;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset mem_read", 32'(mem_read), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async mem_read drop", 32'(mem_read), 32'd0);
    check("async mem_addr clear", 32'(mem_addr), 32'd0);
    mem_ready = 1'b1;
    mem_data  = line_of(15'h0044);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("late ready no resp", 32'(resp_valid), 32'd0);
    check("late ready no mem_read", 32'(mem_read), 32'd0);
    mem_ready = 1'b0;
    mem_data  = '0;
    check("reset access_count", 32'(access_count), 32'd0);
    read_word(15'h0044, 1'b0, 32'h1000_0440, 0);
    read_word(15'h0004, 1'b0, 32'hA0, 0);
    check("after reset hit_count", 32'(hit_count), 32'd0);

    // saturation: one fill then 20 hits
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    read_word(15'h0008, 1'b0, 32'h1000_0080, 0);
    for (int i = 0; i < 20; i++)
      read_word(15'h0009, 1'b1, 32'h1000_0081, 0);
    check("sat hit_count", 32'(s_hit_count), 32'd15);
    check("sat access_count", 32'(s_access_count), 32'd15);
    check("wide hit_count", 32'(hit_count), 32'd20);
    check("wide access_count", 32'(access_count), 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative read cache with LRU replacement. It is the successor to the direct-mapped cache and controller pair in the memory-hierarchy test unit. It accepts word read requests from the requester and answers hits from its tag/data arrays. On a miss it fetches a full line from main memory over a valid/ready handshake, then keeps saturating access and hit counters for hit-rate reporting.

## Interface

Parameters:
- WORD_SIZE, 32: bits per word.
- WORD_COUNT, 4: words per line (power of two, ≥2).
- ADDR_WIDTH, 15: word address width.
- SETS, 8: number of sets (power of two).
- WAYS, 2: associativity (power of two, ≥2).
- CNT_WIDTH, 14: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  read request present.
- req_ready  out  1  cache can accept; equals (state==IDLE) & ~flush.
- req_addr  in  ADDR_WIDTH  word address: offset [OB-1:0], index [OB+IB-1:OB], tag above, where OB=log2(WORD_COUNT) and IB=log2(SETS).
- resp_valid  out  1  one-cycle response strobe.
- resp_data  out  WORD_SIZE  requested word.
- resp_hit  out  1  response was a hit.
- flush  in  1  invalidate all lines.
- mem_read  out  1  line fetch request.
- mem_addr  out  ADDR_WIDTH  line address, offset bits zero.
- mem_ready  in  1  mem_data valid this cycle.
- mem_data  in  WORD_COUNT*WORD_SIZE  full line; word i at bits [i*WORD_SIZE +: WORD_SIZE].
- access_count  out  CNT_WIDTH  accepted requests, saturating.
- hit_count  out  CNT_WIDTH  hits, saturating.

## Operation

States and transitions:
- IDLE → LOOKUP on req_valid & req_ready. The address is registered at that point.
- LOOKUP → RESP on hit. LOOKUP → MISS on miss.
- MISS → RESP on mem_ready.
- RESP → IDLE unconditionally.

Lookup:
- All ways of the indexed set are compared in parallel.
- Hit means the way is valid and its tag matches. At most one way can hit.

Miss handling:
- Victim is the lowest-numbered invalid way. If all ways are valid, the victim is the way with the largest age.
- On mem_ready, the entire line is written into the victim way, the way is marked valid, and the requested word is forwarded to resp_data.

LRU:
- Each set holds a log2(WAYS)-bit age per way, and the ages always form a permutation.
- On a hit or fill of way w, every way with age < age[w] increments, and age[w] becomes 0.

Counters:
- access_count increments on acceptance.
- hit_count increments on entering RESP from LOOKUP.
- Both counters hold at all-ones.

Flush:
- Flush is taken only in IDLE and has priority over a request in the same cycle.
- Flush clears all valid bits in one cycle and resets ages to the way index.
- Counters are unaffected.
- Flush outside IDLE is ignored; the requester must hold it high.

Other rules:
- mem_ready outside MISS is ignored.
- There is no response backpressure.

## Timing

- Accept edge E0. LOOKUP occupies the cycle after E0.
- Hit: at E1 the cache enters RESP. resp_valid and resp_hit are high for exactly the cycle after E1. req_ready returns at E2. Hit throughput is one request per 3 cycles.
- Miss: at E1 mem_read rises with a stable mem_addr. Both are held until an edge at which mem_ready=1. At that edge mem_read falls, resp_valid rises for one cycle with resp_hit=0, and the array and LRU are updated.
- Reset (rst low) values:
  - state IDLE; req_ready 1 once rst is released.
  - resp_valid, resp_hit, mem_read at 0; resp_data and mem_addr at 0.
  - Counters 0, all valid bits 0, age[i]=i.
- Reset mid-MISS drops mem_read immediately. The line is not written, and a late mem_ready is ignored.

## Structure

- Package cache_pkg holds:
  - default parameter constants;
  - the state enum typedef (IDLE, LOOKUP, MISS, RESP);
  - functions extracting tag, index, and offset from an address.
- Sub-module cache_lru holds the per-set age arrays, victim select, and age update. It takes set index, access way, and update strobe as inputs.
- The top holds tag/data/valid arrays, the FSM, and the counters.

## Test plan

Defaults throughout unless a scenario says otherwise.

- **Cold miss then hit:**
  - Read 0x0004 → mem_read with mem_addr 0x0004. Return line {0xD3,0xC2,0xB1,0xA0} (word0=0xA0) → resp_data 0xA0, resp_hit 0.
  - Read 0x0006 → resp_data 0xC2, resp_hit 1, resp_valid 2 edges after accept, access_count 2, hit_count 1.
- **LRU eviction:**
  - Fill 0x0004, then 0x0024 (index 1, tags 0 and 1), then read 0x0004 (hit).
  - Fill 0x0044 → evicts tag 1.
  - 0x0004 then hits; 0x0024 misses.
- **Memory wait:** mem_ready held low 5 cycles → mem_read and mem_addr stable for all 5; resp_valid exactly one cycle after the mem_ready edge.
- **Flush:** fill 0x0004, pulse flush in IDLE together with req_valid → request not accepted. Re-read 0x0004 → miss; counters not cleared.
- **Reset during MISS:**
  - rst low while mem_read=1 → mem_read 0 asynchronously.
  - After release, a late mem_ready is ignored and re-reading the address misses.
- **Saturation:** CNT_WIDTH=4, 20 hits to one line → hit_count 15, access_count 15.
